// File: rtl/banked_stripe_loader.sv
// Streams a flat word sequence into NUM_BANKS single-port SRAM banks in the striped MLP layout.
// Element e of vector k lands in bank e % NUM_BANKS; vectors are packed back-to-back per bank.
module banked_stripe_loader #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NUM_BANKS = 64,
  parameter int unsigned VEC_LEN   = 784,
  parameter int unsigned MAX_VECS  = 200,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           num_vecs,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned DEEP     = (VEC_LEN + NUM_BANKS - 1) / NUM_BANKS;
  localparam int unsigned SHALLOW  = VEC_LEN / NUM_BANKS;
  localparam int unsigned NUM_DEEP = VEC_LEN % NUM_BANKS;
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned ELEM_W   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [BANK_W-1:0] LastBank  = BANK_W'(NUM_BANKS - 1);
  localparam logic [BANK_W:0]   NumDeepB  = (BANK_W + 1)'(NUM_DEEP);
  localparam logic [ELEM_W-1:0] LastElem  = ELEM_W'(VEC_LEN - 1);
  localparam logic [ADDR_W-1:0] DeepStep  = ADDR_W'(DEEP);
  localparam logic [ADDR_W-1:0] ShallStep = ADDR_W'(SHALLOW);

  typedef enum logic [1:0] {StIdle, StLoad, StFin} state_t;

  state_t              state_q;
  logic [7:0]          nv_q;
  logic [7:0]          vec_q;
  logic [BANK_W-1:0]   bank_q;
  logic [ADDR_W-1:0]   col_q;
  logic [ELEM_W-1:0]   elem_q;
  logic [ADDR_W-1:0]   deep_base_q;
  logic [ADDR_W-1:0]   shallow_base_q;

  logic                handshake;
  logic                in_deep;
  logic                last_elem;
  logic                last_vec;
  logic [ADDR_W-1:0]   cur_addr;
  logic [NUM_BANKS-1:0] cur_onehot;

  assign handshake  = in_valid & in_ready & (state_q == StLoad);
  // The first NUM_DEEP banks hold one extra row per vector.
  assign in_deep    = ({1'b0, bank_q} < NumDeepB);
  assign cur_addr   = (in_deep ? deep_base_q : shallow_base_q) + col_q;
  assign cur_onehot = NUM_BANKS'(1) << bank_q;
  assign last_elem  = (elem_q == LastElem);
  assign last_vec   = (vec_q == (nv_q - 8'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      nv_q           <= '0;
      vec_q          <= '0;
      bank_q         <= '0;
      col_q          <= '0;
      elem_q         <= '0;
      deep_base_q    <= '0;
      shallow_base_q <= '0;
      in_ready       <= 1'b0;
      wr_en          <= '0;
      wr_addr        <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      wr_en <= '0;
      done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_vecs != 8'd0) begin
              nv_q           <= num_vecs;
              vec_q          <= '0;
              bank_q         <= '0;
              col_q          <= '0;
              elem_q         <= '0;
              deep_base_q    <= '0;
              shallow_base_q <= '0;
              in_ready       <= 1'b1;
              busy           <= 1'b1;
              state_q        <= StLoad;
            end else begin
              done    <= 1'b1;
              state_q <= StFin;
            end
          end
        end
        StLoad: begin
          if (handshake) begin
            wr_en   <= cur_onehot;
            wr_addr <= cur_addr;
            wr_data <= in_data;
            if (last_elem) begin
              bank_q         <= '0;
              col_q          <= '0;
              elem_q         <= '0;
              vec_q          <= vec_q + 8'd1;
              deep_base_q    <= deep_base_q + DeepStep;
              shallow_base_q <= shallow_base_q + ShallStep;
              if (last_vec) begin
                in_ready <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state_q  <= StFin;
              end
            end else begin
              elem_q <= elem_q + ELEM_W'(1);
              if (bank_q == LastBank) begin
                bank_q <= '0;
                col_q  <= col_q + ADDR_W'(1);
              end else begin
                bank_q <= bank_q + BANK_W'(1);
              end
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
